// File: rtl/nco_sin_cos_if.sv
// Control and sample bus of the quadrature NCO.
// The master side drives configuration and enable, and the slave side returns samples.
interface nco_sin_cos_if #(
  parameter int PHASE_W = 32,
  parameter int DATA_W  = 8
);
  logic                      en;
  logic                      cfg_load;
  logic                      sync_clr;
  logic [PHASE_W-1:0]        ftw_in;
  logic [PHASE_W-1:0]        pofs_in;
  logic signed [DATA_W-1:0]  data_sin;
  logic signed [DATA_W-1:0]  data_cos;
  logic                      data_valid;
  logic [PHASE_W-1:0]        phase_out;

  modport master (
    output en, cfg_load, sync_clr, ftw_in, pofs_in,
    input  data_sin, data_cos, data_valid, phase_out
  );

  modport slave (
    input  en, cfg_load, sync_clr, ftw_in, pofs_in,
    output data_sin, data_cos, data_valid, phase_out
  );
endinterface

// File: rtl/nco_sin_cos.sv
// Quadrature NCO: a phase accumulator feeds a 3-stage pipeline.
// The stages are quadrant fold, quarter-wave LUT read, and sign/output register.
module nco_sin_cos #(
  parameter int                 PHASE_W     = 32,
  parameter int                 LUT_AW      = 8,
  parameter int                 DATA_W      = 8,
  parameter logic [PHASE_W-1:0] DEFAULT_FTW = 32'h0100_0000
) (
  input logic         Clk,
  input logic         Rst_n,
  nco_sin_cos_if.slave bus
);

  localparam int                 N       = 1 << LUT_AW;
  localparam int                 AMP_MAX = (1 << (DATA_W - 1)) - 1;
  localparam logic [PHASE_W-1:0] QTR     = PHASE_W'(1) << (PHASE_W - 2);
  localparam longint             ONE     = 64'sd1 << 30;
  localparam longint             PI_FX   = 64'sd3373259426;

  // Elaboration-time sine in Q30 fixed point (Taylor series to x^15), rounded to amplitude.
  function automatic longint lut_val(input int k);
    longint x, term, sum;
    x    = (PI_FX * longint'(k)) / longint'(2 * N);
    term = x;
    sum  = x;
    for (int unsigned n = 1; n <= 7; n++) begin
      term = -(((term * x) / ONE) * x / ONE) / longint'(2 * n * (2 * n + 1));
      sum  = sum + term;
    end
    return (longint'(AMP_MAX) * sum + ONE / 2) / ONE;
  endfunction

  function automatic logic [LUT_AW:0] fold_addr(input logic [PHASE_W-1:0] x);
    logic [LUT_AW:0] a;
    a = {1'b0, x[PHASE_W-3 -: LUT_AW]};
    return x[PHASE_W-2] ? (LUT_AW+1)'(N) - a : a;
  endfunction

  logic [DATA_W-2:0] lut [N+1];

  for (genvar k = 0; k <= N; k++) begin : g_lut
    localparam logic [DATA_W-2:0] V = (DATA_W-1)'(lut_val(k));
    assign lut[k] = V;
  end

  logic [PHASE_W-1:0] acc, ftw_r, pofs_r;
  logic [PHASE_W-1:0] acc_cur, p_sin, p_cos;

  always_comb begin
    acc_cur = bus.sync_clr ? '0 : acc;
    p_sin   = acc_cur + pofs_r;
    p_cos   = p_sin + QTR;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc    <= '0;
      ftw_r  <= DEFAULT_FTW;
      pofs_r <= '0;
    end else begin
      acc <= bus.en ? acc_cur + ftw_r : acc_cur;
      if (bus.cfg_load) begin
        ftw_r  <= bus.ftw_in;
        pofs_r <= bus.pofs_in;
      end
    end
  end

  logic                s1_valid, s1_sin_neg, s1_cos_neg;
  logic [LUT_AW:0]     s1_sin_addr, s1_cos_addr;
  logic [PHASE_W-1:0]  s1_phase;
  logic                s2_valid, s2_sin_neg, s2_cos_neg;
  logic [DATA_W-2:0]   s2_sin_mag, s2_cos_mag;
  logic [PHASE_W-1:0]  s2_phase;
  logic signed [DATA_W-1:0] sin_s, cos_s;

  always_comb begin
    sin_s = signed'({1'b0, s2_sin_mag});
    cos_s = signed'({1'b0, s2_cos_mag});
  end

  // Stages 1 and 2 advance unconditionally; bubbles travel as valid=0.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_valid    <= 1'b0;
      s1_sin_neg  <= 1'b0;
      s1_cos_neg  <= 1'b0;
      s1_sin_addr <= '0;
      s1_cos_addr <= '0;
      s1_phase    <= '0;
      s2_valid    <= 1'b0;
      s2_sin_neg  <= 1'b0;
      s2_cos_neg  <= 1'b0;
      s2_sin_mag  <= '0;
      s2_cos_mag  <= '0;
      s2_phase    <= '0;
    end else begin
      s1_valid    <= bus.en;
      s1_sin_neg  <= p_sin[PHASE_W-1];
      s1_cos_neg  <= p_cos[PHASE_W-1];
      s1_sin_addr <= fold_addr(p_sin);
      s1_cos_addr <= fold_addr(p_cos);
      s1_phase    <= p_sin;
      s2_valid    <= s1_valid;
      s2_sin_neg  <= s1_sin_neg;
      s2_cos_neg  <= s1_cos_neg;
      s2_sin_mag  <= lut[s1_sin_addr];
      s2_cos_mag  <= lut[s1_cos_addr];
      s2_phase    <= s1_phase;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bus.data_valid <= 1'b0;
      bus.data_sin   <= '0;
      bus.data_cos   <= '0;
      bus.phase_out  <= '0;
    end else begin
      bus.data_valid <= s2_valid;
      if (s2_valid) begin
        bus.data_sin  <= s2_sin_neg ? -sin_s : sin_s;
        bus.data_cos  <= s2_cos_neg ? -cos_s : cos_s;
        bus.phase_out <= s2_phase;
      end
    end
  end

endmodule

// File: tb/tb_nco_sin_cos.sv
// Scoreboard bench for nco_sin_cos: stimulus pushes the expected phase, the hand-computed sin/cos, and the due cycle.
// A negedge monitor pops and compares every valid output and checks that the outputs hold during gaps.
module tb_nco_sin_cos;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  nco_sin_cos_if #(.PHASE_W(32), .DATA_W(8)) bus ();

  nco_sin_cos #(
    .PHASE_W(32), .LUT_AW(8), .DATA_W(8), .DEFAULT_FTW(32'h0100_0000)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .bus(bus)
  );

  typedef struct {
    logic        chk;
    int          es;
    int          ec;
    logic [31:0] ph;
    longint      due;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_valid = 0;
  longint      cyc     = 0;
  logic [31:0] last_ph = '0;
  logic [31:0] m_acc, m_ftw, m_pofs;

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (Rst_n) begin
      if (bus.data_valid) begin
        n_valid++;
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: got phase=%h, required no sample", bus.phase_out);
        end else begin
          e = q.pop_front();
          if (cyc != e.due || bus.phase_out !== e.ph) begin
            n_fail++;
            $display("FAIL sample_phase: got phase=%h at cycle %0d, required %h at cycle %0d",
                     bus.phase_out, cyc, e.ph, e.due);
          end
          if (e.chk) begin
            n_tests++;
            if ($signed(bus.data_sin) != e.es || $signed(bus.data_cos) != e.ec) begin
              n_fail++;
              $display("FAIL sample_value (phase %h): got sin=%0d cos=%0d, required sin=%0d cos=%0d",
                       e.ph, $signed(bus.data_sin), $signed(bus.data_cos), e.es, e.ec);
            end
          end
          last_ph = e.ph;
        end
      end else begin
        n_tests++;
        if (bus.phase_out !== last_ph) begin
          n_fail++;
          $display("FAIL hold_phase: got %h, required %h", bus.phase_out, last_ph);
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic clr, input logic ld,
                      input logic [31:0] f, input logic [31:0] po,
                      input logic chk, input int es, input int ec);
    logic [31:0] cur;
    bus.en = en; bus.sync_clr = clr; bus.cfg_load = ld;
    bus.ftw_in = f; bus.pofs_in = po;
    cur = clr ? 32'h0 : m_acc;
    if (en) begin
      q.push_back('{chk, es, ec, cur + m_pofs, cyc + 3});
      m_acc = cur + m_ftw;
    end else begin
      m_acc = cur;
    end
    if (ld) begin
      m_ftw  = f;
      m_pofs = po;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0);
  endtask

  task automatic drain(input string name);
    idle(4);
    check(name, q.size(), 0);
  endtask

  initial begin
    int v0;
    bus.en = 1'b0; bus.sync_clr = 1'b0; bus.cfg_load = 1'b0;
    bus.ftw_in = '0; bus.pofs_in = '0;
    m_acc = '0; m_ftw = 32'h0100_0000; m_pofs = '0;
    #12;
    check("reset_valid", bus.data_valid, 0);
    check("reset_sin", bus.data_sin, 0);
    check("reset_cos", bus.data_cos, 0);
    check("reset_phase", bus.phase_out, 0);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // Default FTW 2^24: 256-sample period, sample 256 wraps to sample 0.
    for (int i = 0; i <= 256; i++) begin
      case (i)
        0, 256:  step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 0, 127);
        1:       step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 3, 127);
        2:       step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 6, 127);
        64:      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 127, 0);
        128:     step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 0, -127);
        192:     step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, -127, 0);
        default: step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0);
      endcase
    end
    drain("drain_sweep");

    // Nyquist: ftw = 2^31.
    step(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 0, (i % 2 == 0) ? 127 : -127);
    drain("drain_nyquist");

    // DC at +90 degrees: ftw = 0, pofs = 2^30.
    step(1'b0, 1'b1, 1'b1, 32'h0, 32'h4000_0000, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 127, 0);
    drain("drain_dc");

    // Enable pattern 1,0,1,1,0.
    step(1'b0, 1'b1, 1'b1, 32'h0100_0000, 32'h0, 1'b0, 0, 0);
    idle(4);
    v0 = n_valid;
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 0, 127);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 3, 127);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 6, 127);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0);
    drain("drain_toggle");
    check("toggle_pulses", n_valid - v0, 3);

    // 100 samples, then sync_clr + cfg_load + en together, then a negative frequency.
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 32'hFF00_0000, 32'h0, 1'b1, 0, 127);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 3, 127);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 0, 127);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, -3, 127);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, -6, 127);
    drain("drain_negfreq");

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0);
    bus.en = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.data_valid, 0);
    check("async_rst_sin", bus.data_sin, 0);
    check("async_rst_cos", bus.data_cos, 0);
    q.delete();
    m_acc = '0; m_ftw = 32'h0100_0000; m_pofs = '0;
    last_ph = '0;
    @(posedge Clk);
    #3 Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 0, 127);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 3, 127);
    drain("drain_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
